tcm_arbiter: RTL and testbench



---
 rtl/tcm_pkg.sv | 26 ++
 rtl/arb_wait_counter.sv | 47 ++++
 rtl/tcm_arbiter.sv | 136 +++++++++++++
 tb/tb_tcm_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_pkg.sv
// -----------------------------------------------------------------------------
// tcm_pkg
// Types and defaults shared by the TCM arbiter slice.
//   TCM_AW / TCM_DW : default word-address and data widths of one TCM instance
//   tcm_req_t       : bundle of one requester's access fields
//   tcm_owner_e     : which requester owns the in-flight response
// -----------------------------------------------------------------------------
package tcm_pkg;

    localparam int TCM_AW = 10;
    localparam int TCM_DW = 32;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [TCM_DW/8-1:0]   be;
        logic [TCM_AW-1:0]     addr;
        logic [TCM_DW-1:0]     wdata;
    } tcm_req_t;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } tcm_owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// -----------------------------------------------------------------------------
// arb_wait_counter
// Saturating wait counter used to bound how long the low-priority requester
// can be held off.
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active-high (count returns to 0)
//   inc    : count one more stalled cycle (saturates at MAX)
//   clr    : return the count to 0 (wins over inc)
//   at_max : count has reached MAX
// -----------------------------------------------------------------------------
module arb_wait_counter #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != MAX_V)) begin
            cnt_next = cnt_reg + ONE_V;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_max = (cnt_reg == MAX_V);

endmodule

// File: rtl/tcm_arbiter.sv
// -----------------------------------------------------------------------------
// tcm_arbiter
// Shares one single-port TCM between the core load/store path (port 0, fixed
// priority) and a program/data loader (port 1). Read data from the SRAM
// (1-cycle latency) is steered back to whichever port issued the access; every
// accepted access, read or write, gets exactly one rvalid one cycle later.
//
// Build option: define TCM_ARB_STARVE_GUARD_EN to add the port-1 starvation
// guard (forced port-1 grant after MAX_WAIT stalled cycles). Without it, port 0
// always wins and MAX_WAIT is unused.
//
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   m0_* / m1_* (req,we,be,addr,wdata) : requester inputs, held until granted
//   m0_gnt / m1_gnt                : request accepted this cycle (combinational)
//   m0_rvalid / m1_rvalid          : response for the access granted last cycle
//   m0_rdata / m1_rdata            : read data, zero unless own rvalid on a read
//   mem_cs, mem_we, mem_be, mem_addr, mem_wdata : SRAM command, zero when idle
//   mem_rdata                      : SRAM read data, 1 cycle after a read
// -----------------------------------------------------------------------------
module tcm_arbiter
    import tcm_pkg::*;
#(
    parameter int AW       = TCM_AW,
    parameter int DW       = TCM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [DW/8-1:0] m0_be,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [DW/8-1:0] m1_be,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    output logic            m0_gnt,
    output logic            m1_gnt,
    output logic            m0_rvalid,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m0_rdata,
    output logic [DW-1:0]   m1_rdata,
    output logic            mem_cs,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    logic       force_m1;
    logic       gnt0_raw;
    logic       gnt1_raw;

    logic       rsp_vld_reg;
    tcm_owner_e rsp_owner_reg;
    logic       rsp_rd_reg;

`ifdef TCM_ARB_STARVE_GUARD_EN
    logic at_max;

    // Counts cycles port 1 has been requesting without a grant.
    arb_wait_counter #(
        .W   (4),
        .MAX (MAX_WAIT)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .inc    (m1_req && !gnt1_raw),
        .clr    (!m1_req || gnt1_raw),
        .at_max (at_max)
    );

    assign force_m1 = m1_req && at_max;
`else
    logic [3:0] unused_max_wait;
    assign unused_max_wait = 4'(MAX_WAIT);
    assign force_m1        = 1'b0;
`endif

    // Internal grant decision feeds the response registers and the wait
    // counter; those are held in reset anyway, so rst only gates the outputs.
    assign gnt1_raw = m1_req && (force_m1 || !m0_req);
    assign gnt0_raw = m0_req && !gnt1_raw;

    assign m0_gnt = gnt0_raw && !rst;
    assign m1_gnt = gnt1_raw && !rst;

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m0_gnt) begin
            mem_cs    = 1'b1;
            mem_we    = m0_we;
            mem_be    = m0_be;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_cs    = 1'b1;
            mem_we    = m1_we;
            mem_be    = m1_be;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
    end

    // One response slot: the SRAM answers exactly one cycle after the grant,
    // so back-to-back grants simply overwrite the slot each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_reg   <= 1'b0;
            rsp_owner_reg <= OWN_M0;
            rsp_rd_reg    <= 1'b0;
        end else begin
            rsp_vld_reg <= gnt0_raw || gnt1_raw;
            if (gnt0_raw || gnt1_raw) begin
                rsp_owner_reg <= gnt1_raw ? OWN_M1 : OWN_M0;
                rsp_rd_reg    <= gnt1_raw ? !m1_we : !m0_we;
            end
        end
    end

    assign m0_rvalid = rsp_vld_reg && (rsp_owner_reg == OWN_M0);
    assign m1_rvalid = rsp_vld_reg && (rsp_owner_reg == OWN_M1);

    // Write acknowledges carry zero data; only reads forward the SRAM output.
    assign m0_rdata = (m0_rvalid && rsp_rd_reg) ? mem_rdata : '0;
    assign m1_rdata = (m1_rvalid && rsp_rd_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_tcm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tcm_arbiter
// Directed bench for tcm_arbiter with a behavioural 1-cycle SRAM. Stimulus
// checks grants and the SRAM command in the grant cycle and queues the expected
// response; a monitor pops and compares whenever an rvalid appears.
// Honours TCM_ARB_STARVE_GUARD_EN for the starvation sequence.
// -----------------------------------------------------------------------------
module tb_tcm_arbiter;

`ifdef TCM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_be = '0;
    logic [9:0]  m0_addr = '0;
    logic [31:0] m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0]  m1_be = '0;
    logic [9:0]  m1_addr = '0;
    logic [31:0] m1_wdata = '0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_cs, mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    tcm_arbiter #(
        .AW(10), .DW(32), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural single-port SRAM, preloaded on the first clock edge.
    logic [31:0] mem_model [0:1023];
    bit          init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            mem_model[0]     <= 32'h0000_0005;
            mem_model[10'h20] <= 32'h1122_3344;
            init_done        <= 1'b1;
        end else if (mem_cs) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= mem_model[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_m0(input bit req, input bit we, input logic [3:0] be,
                          input logic [9:0] addr, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
    endtask

    task automatic set_m1(input bit req, input bit we, input logic [3:0] be,
                          input logic [9:0] addr, input logic [31:0] wd);
        m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd;
    endtask

    // Checks the grant cycle, queues the expected response, returns 1 ns
    // after the closing clock edge ready for the next drive.
    task automatic grant_cycle(input string name, input bit e0, input bit e1,
                               input logic [31:0] erd, input bit push);
        exp_t e;
        @(negedge clk);
        chk({name, ".m0_gnt"}, 32'(m0_gnt), 32'(e0));
        chk({name, ".m1_gnt"}, 32'(m1_gnt), 32'(e1));
        chk({name, ".mem_cs"}, 32'(mem_cs), 32'(e0 | e1));
        if (e0 | e1) begin
            chk({name, ".mem_addr"},  32'(mem_addr),  e1 ? 32'(m1_addr) : 32'(m0_addr));
            chk({name, ".mem_we"},    32'(mem_we),    e1 ? 32'(m1_we)   : 32'(m0_we));
            chk({name, ".mem_be"},    32'(mem_be),    e1 ? 32'(m1_be)   : 32'(m0_be));
            chk({name, ".mem_wdata"}, mem_wdata,      e1 ? m1_wdata     : m0_wdata);
        end
        if (push && (e0 | e1)) begin
            e.owner = e1;
            e.data  = erd;
            e.due   = cyc + 1;
            exp_q.push_back(e);
        end
        $display("txn %-14s cyc=%0d gnt0=%0b gnt1=%0b mem_cs=%0b addr=0x%03h", name, cyc,
                 m0_gnt, m1_gnt, mem_cs, mem_addr);
        @(posedge clk);
        #1;
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (m0_rvalid || m1_rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: m0_rvalid=%0b m1_rvalid=%0b at cyc %0d, expected none",
                         m0_rvalid, m1_rvalid, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp.m0_rvalid", 32'(m0_rvalid), 32'(!mon_e.owner));
                chk("rsp.m1_rvalid", 32'(m1_rvalid), 32'(mon_e.owner));
                chk("rsp.rdata", mon_e.owner ? m1_rdata : m0_rdata, mon_e.data);
                chk("rsp.other_rdata", mon_e.owner ? m0_rdata : m1_rdata, 32'h0);
                chk("rsp.cycle", 32'(cyc), 32'(mon_e.due));
                $display("rsp owner=m%0d data=0x%08h cyc=%0d", mon_e.owner, mon_e.data, cyc);
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_rvalid: no rvalid at cyc %0d, expected m%0d response due cyc %0d",
                     cyc, mon_e.owner, mon_e.due);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit e1;

        // Reset state
        @(negedge clk);
        chk("rst.m0_gnt",    32'(m0_gnt),    32'h0);
        chk("rst.m1_gnt",    32'(m1_gnt),    32'h0);
        chk("rst.m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("rst.m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("rst.mem_cs",    32'(mem_cs),    32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Only port 0 reads 0x000 (holds 0x5)
        set_m0(1'b1, 1'b0, 4'hF, 10'h000, 32'h0);
        grant_cycle("m0_rd0", 1'b1, 1'b0, 32'h0000_0005, 1'b1);
        set_m0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        grant_cycle("idle", 1'b0, 1'b0, 32'h0, 1'b1);

        // Port 1 writes 0x019, then port 0 reads it back
        set_m1(1'b1, 1'b1, 4'hF, 10'h019, 32'h0087_8793);
        grant_cycle("m1_wr19", 1'b0, 1'b1, 32'h0, 1'b1);
        set_m1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        set_m0(1'b1, 1'b0, 4'hF, 10'h019, 32'h0);
        grant_cycle("m0_rd19", 1'b1, 1'b0, 32'h0087_8793, 1'b1);

        // Simultaneous requests: port 0 first, then port 1
        set_m0(1'b1, 1'b0, 4'hF, 10'h000, 32'h0);
        set_m1(1'b1, 1'b0, 4'hF, 10'h019, 32'h0);
        grant_cycle("both_m0", 1'b1, 1'b0, 32'h0000_0005, 1'b1);
        set_m0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        grant_cycle("both_m1", 1'b0, 1'b1, 32'h0087_8793, 1'b1);
        set_m1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);

        // Port 0 held for 10 cycles against a pending port 1 read
        set_m0(1'b1, 1'b0, 4'hF, 10'h000, 32'h0);
        set_m1(1'b1, 1'b0, 4'hF, 10'h019, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            e1 = GUARD && (c == 5);
            grant_cycle($sformatf("starve_c%0d", c), !e1, e1,
                        e1 ? 32'h0087_8793 : 32'h0000_0005, 1'b1);
            if (e1) set_m1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        end
        set_m0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
`ifndef TCM_ARB_STARVE_GUARD_EN
        grant_cycle("starve_tail", 1'b0, 1'b1, 32'h0087_8793, 1'b1);
        set_m1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
`endif

        // Alternating grants 0, 1, 0 with a partial byte-enable write
        set_m0(1'b1, 1'b0, 4'hF, 10'h000, 32'h0);
        grant_cycle("alt_m0", 1'b1, 1'b0, 32'h0000_0005, 1'b1);
        set_m0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        set_m1(1'b1, 1'b1, 4'hC, 10'h020, 32'hA5A5_0000);
        grant_cycle("alt_m1_wr", 1'b0, 1'b1, 32'h0, 1'b1);
        set_m1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        set_m0(1'b1, 1'b0, 4'hF, 10'h020, 32'h0);
        grant_cycle("alt_m0_rd", 1'b1, 1'b0, 32'hA5A5_3344, 1'b1);
        set_m0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        grant_cycle("idle2", 1'b0, 1'b0, 32'h0, 1'b1);

        // Reset right after a port 0 read grant discards the response
        set_m0(1'b1, 1'b0, 4'hF, 10'h000, 32'h0);
        grant_cycle("rst_gnt", 1'b1, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        set_m1(1'b1, 1'b1, 4'hF, 10'h005, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("inrst.m0_gnt",    32'(m0_gnt),    32'h0);
        chk("inrst.m1_gnt",    32'(m1_gnt),    32'h0);
        chk("inrst.m0_rvalid", 32'(m0_rvalid), 32'h0);
        chk("inrst.m1_rvalid", 32'(m1_rvalid), 32'h0);
        chk("inrst.m0_rdata",  m0_rdata,       32'h0);
        chk("inrst.m1_rdata",  m1_rdata,       32'h0);
        chk("inrst.mem_cs",    32'(mem_cs),    32'h0);
        chk("inrst.mem_we",    32'(mem_we),    32'h0);
        chk("inrst.mem_be",    32'(mem_be),    32'h0);
        chk("inrst.mem_addr",  32'(mem_addr),  32'h0);
        chk("inrst.mem_wdata", mem_wdata,      32'h0);
        $display("txn %-14s cyc=%0d reset asserted with response pending", "rst_pulse", cyc);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_m0(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        set_m1(1'b0, 1'b0, 4'h0, 10'h000, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("end.queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
